serial_frame_tx: RTL
====================

Name: serial_frame_tx

Overview:
- Serial frame transmitter: the sending end of the single-wire frame protocol consumed by the team's serial receiver/demux controller.
- Accepts a parallel request (destination port, data length, data word) and serializes it onto SerOut as: start bit, port field, length field, data bits, stop.
- Sits between a parallel producer and the serial line; all state advance is qualified by the shared clkEn tick.

Parameters:
- PORT_W, 2, width of port field, sent MSB first.
- LEN_W, 4, width of length field, sent MSB first; also the data bit count.
- DATA_W, 16, width of data input register; must be >= 2**LEN_W - 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- clkEn  input  1  tick enable; state, counters and shifters change only on clk edges with clkEn=1.
- start  input  1  request strobe; sampled only in IDLE on an enabled edge.
- port  input  PORT_W  destination port; captured at accept.
- len  input  LEN_W  number of data bits N (0..2**LEN_W-1); captured at accept.
- data  input  DATA_W  payload; bits data[N-1:0] are sent, MSB first; captured at accept.
- SerOut  output  1  serial line; idles high.
- busy  output  1  high from the edge after accept through the STOP state.
- Done  output  1  high while in STOP, i.e. exactly one enabled tick per frame.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; SerOut=1, busy=0, Done=0; the port, len and data capture registers and the bit counter clear to 0.
- Reset mid-frame aborts immediately: SerOut goes high without waiting for a clock edge, and the partial frame is not completed.
- Outputs are Moore: a function of the state, the capture registers and the bit counter only; there is no combinational path from any input.
- States and transitions (each taken on an enabled edge):
  - IDLE: SerOut=1. If start=1, capture port, len and data, then go to START; otherwise stay.
  - START: SerOut=0 for one tick. Load bit counter with PORT_W-1, go to PORT.
  - PORT: SerOut=port_q[cnt]. At cnt=0 load LEN_W-1 and go to LEN; otherwise decrement.
  - LEN: SerOut=len_q[cnt]. At cnt=0: if len_q=0 go to STOP, else load len_q-1 and go to DATA. Otherwise decrement.
  - DATA: SerOut=data_q[cnt]. At cnt=0 go to STOP; otherwise decrement.
  - STOP: SerOut=1, Done=1, busy=1. Next state is IDLE.
  - Undefined encodings go to IDLE with SerOut=1.
- Frame length is 1 + PORT_W + LEN_W + N + 1 ticks. With defaults: 8+N ticks.
- Latency: the first SerOut=0 appears in the tick immediately after the accepting edge.
- start is ignored while busy=1, including during STOP; it is not queued.
- Back-to-back frames: start held high through STOP is accepted in the following IDLE tick. The minimum line-high gap between frames is therefore 2 ticks (STOP plus one IDLE).
- Inputs may change freely after accept; only the captured copies are transmitted.
- clkEn=0: all registers hold and all outputs hold their current values, so a tick stretches over any number of clocks. Done stays high across a stall inside STOP.
- Bit counter width is max(PORT_W, LEN_W) bits. It never underflows: every decrement is guarded by cnt=0.
- Data bits above N-1 are never transmitted.

Test Plan:
- Reset release with clkEn=1, start=0 for 10 ticks -> SerOut=1, busy=0, Done=0 throughout. Assert rst=0 mid-DATA -> SerOut=1 and busy=0 immediately, with no clock edge.
- port=2'b10, len=4'd3, data=16'h0005, start pulse, clkEn=1 -> SerOut per tick 0,1,0,0,0,1,1,1,0,1,1. Done high only on tick 11; busy high on ticks 1-11.
- len=0, port=2'b01 -> SerOut 0,0,1,0,0,0,0,1. Done on tick 8; no data bits sent.
- len=4'd15, data=16'hA5C3 -> the 15 data bits equal data[14:0] MSB first (0100101 11000011). Frame is 23 ticks; bit 15 of data is never driven.
- clkEn pulsed every 3rd clock during the test-2 frame -> identical SerOut tick sequence. Each value is held 3 clocks; Done is high for 3 clocks.
- Checks on start:
  - start held high continuously: frames repeat, separated by STOP plus one IDLE high tick.
  - start pulses during busy: ignored.
  - port/len/data changed after accept: the frame in flight is unaffected.

Source files
------------

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: serializes {start, port, len, data[N-1:0], stop}
// onto a single idle-high line, advancing one bit per enabled clkEn tick.
module serial_frame_tx #(
  parameter int PORT_W = 2,
  parameter int LEN_W  = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clkEn,
  input  logic              start,
  input  logic [PORT_W-1:0] port,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] data,
  output logic              SerOut,
  output logic              busy,
  output logic              Done
);

  localparam int CNT_W = (PORT_W > LEN_W) ? PORT_W : LEN_W;
  localparam int SEL_W = (DATA_W > CNT_W) ? DATA_W : CNT_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_PORT  = 3'd2,
    S_LEN   = 3'd3,
    S_DATA  = 3'd4,
    S_STOP  = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [PORT_W-1:0]   port_q, port_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [SEL_W-1:0]    sel_vec;
  logic                sel_bit;

  // NOTE: every signal assigned in this block gets a hold/default value first,
  // so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    len_d   = len_q;
    data_d  = data_q;
    cnt_d   = cnt_q;

    if (clkEn) begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            port_d  = port;
            len_d   = len;
            data_d  = data;
            state_d = S_START;
          end
        end
        S_START: begin
          cnt_d   = CNT_W'(PORT_W - 1);
          state_d = S_PORT;
        end
        S_PORT: begin
          if (cnt_q == '0) begin
            cnt_d   = CNT_W'(LEN_W - 1);
            state_d = S_LEN;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_LEN: begin
          if (cnt_q == '0) begin
            if (len_q == '0) begin
              state_d = S_STOP;
            end else begin
              cnt_d   = CNT_W'(len_q) - CNT_W'(1);
              state_d = S_DATA;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_DATA: begin
          if (cnt_q == '0) begin
            state_d = S_STOP;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_STOP:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of block order.
  // NOTE: the capture registers are ordinary flops (not a memory array), so
  // clearing them in reset is cheap and keeps the line state fully defined.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      port_q  <= '0;
      len_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      len_q   <= len_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  // Field currently being shifted out, zero-extended so one bit-select
  // expression serves port, length and data.
  always_comb begin
    sel_vec = '0;
    case (state_q)
      S_PORT:  sel_vec = SEL_W'(port_q);
      S_LEN:   sel_vec = SEL_W'(len_q);
      S_DATA:  sel_vec = SEL_W'(data_q);
      default: sel_vec = '0;
    endcase
    sel_bit = |(sel_vec & (SEL_W'(1) << cnt_q));
  end

  // Moore outputs: depend only on registered state, never on inputs.
  always_comb begin
    SerOut = 1'b1;
    busy   = 1'b0;
    Done   = 1'b0;
    case (state_q)
      S_IDLE:  SerOut = 1'b1;
      S_START: begin
        SerOut = 1'b0;
        busy   = 1'b1;
      end
      S_PORT, S_LEN, S_DATA: begin
        SerOut = sel_bit;
        busy   = 1'b1;
      end
      S_STOP: begin
        SerOut = 1'b1;
        busy   = 1'b1;
        Done   = 1'b1;
      end
      default: SerOut = 1'b1;
    endcase
  end

endmodule
